// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Shares the start/busy/valid handshake with the shift-add multiplier.
module divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic             dbz_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [CW-1:0]    cnt;
   logic             dbz;

   logic [WIDTH:0]   trial;
   logic             fits;
   logic [WIDTH-1:0] rem_nx;

   // A restored remainder is always < divisor, so WIDTH bits hold it; only
   // the shifted trial value needs the extra bit for the compare.
   always_comb begin
      trial  = {rem, dvd[cnt]};
      fits   = trial >= {1'b0, dvs};
      rem_nx = fits ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= IDLE;
         dvd   <= '0;
         dvs   <= '0;
         rem   <= '0;
         quo   <= '0;
         cnt   <= '0;
         dbz   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  if (divisor_i != '0) begin
                     dvd   <= dividend_i;
                     dvs   <= divisor_i;
                     rem   <= '0;
                     quo   <= '0;
                     dbz   <= 1'b0;
                     cnt   <= CW'(WIDTH - 1);
                     state <= CALC;
                  end else begin
                     quo   <= '1;
                     rem   <= dividend_i;
                     dbz   <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            CALC: begin
               rem      <= rem_nx;
               quo[cnt] <= fits;
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o      = (state == CALC);
   assign valid_o     = (state == DONE);
   assign dbz_o       = dbz;
   assign quotient_o  = quo;
   assign remainder_o = rem;

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of divider against plain integer division.
module tb_divider;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         valid;
   logic         dbz;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   int total = 0;
   int passed = 0;

   divider #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .busy_o      (busy),
      .valid_o     (valid),
      .dbz_o       (dbz),
      .quotient_o  (quotient),
      .remainder_o (remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   // One active edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("busy_valid_excl", {31'd0, busy & valid}, 32'd0);
   endtask

   task automatic start_op(input int a, input int b);
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Reference: integer division; divide-by-zero gives all-ones quotient.
   task automatic expect_result(input string tag, input int a, input int b, input int nb);
      int eq, er;
      if (b == 0) begin
         eq = (1 << W) - 1;
         er = a;
         chk({tag, "_lat"}, nb, 0);
      end else begin
         eq = a / b;
         er = a % b;
         chk({tag, "_lat"}, nb, W);
         chk({tag, "_inv"}, {31'd0, (eq * b + er == a) && (er < b)}, 32'd1);
      end
      chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_dbz"}, {31'd0, dbz}, (b == 0) ? 32'd1 : 32'd0);
   endtask

   // Counts busy cycles (bounded) and leaves the bench sampling on the valid cycle.
   task automatic wait_busy(output int nb);
      nb = 0;
      for (int i = 0; i < 4 * W && busy; i++) begin
         nb++;
         tick();
      end
   endtask

   task automatic do_div(input string tag, input int a, input int b);
      int nb;
      start_op(a, b);
      if (b != 0) chk({tag, "_vdrop"}, {31'd0, valid}, 32'd0);
      wait_busy(nb);
      expect_result(tag, a, b, nb);
   endtask

   initial begin
      int nb;
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      tick(); tick();
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_dbz",   {31'd0, dbz},   32'd0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      rst_n = 1'b1;
      tick();

      do_div("d13_4", 13, 4);
      do_div("d255_1", 255, 1);
      do_div("d7_9", 7, 9);
      do_div("d0_5", 0, 5);
      do_div("d200_200", 200, 200);
      do_div("d100_0", 100, 0);

      // Operand change and start pulse mid-calculation are ignored.
      start_op(50, 7);
      nb = 1;
      tick(); tick(); nb += 2;
      dividend = 8'd99; divisor = 8'd3; start = 1'b1;
      tick(); nb++;
      start = 1'b0;
      begin
         int rest;
         wait_busy(rest);
         expect_result("d50_7_mid", 50, 7, nb + rest - 1);
      end

      // Reset in the fourth CALC cycle aborts the operation.
      start_op(50, 7);
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy",  {31'd0, busy},  32'd0);
      chk("abort_valid", {31'd0, valid}, 32'd0);
      chk("abort_dbz",   {31'd0, dbz},   32'd0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      do_div("d9_2", 9, 2);

      // Back-to-back from DONE while valid is high.
      do_div("d60_8", 60, 8);

      for (int n = 0; n < 1000; n++) begin
         int a, b;
         a = int'($urandom_range(0, (1 << W) - 1));
         b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
         if ($urandom_range(0, 3) == 0) tick();
         do_div("rnd", a, b);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
